// File: rtl/fifo_protocol_checker.sv
// Shadow-model protocol checker for the synchronous FIFO. It compares the FIFO flags,
// handshakes and read data against its own model and records mismatches in sticky error state.
module fifo_protocol_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_TH      = DEPTH - 1,
  parameter int AE_TH      = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       full,
  input  logic                       empty,
  input  logic                       almostfull,
  input  logic                       almostempty,
  input  logic                       wr_ack,
  input  logic                       overflow,
  input  logic                       underflow,
  output logic [7:0]                 err_vec,
  output logic                       err_any,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic                       first_err_valid,
  output logic [2:0]                 first_err_code,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [OW-1:0] C_FULL = OW'(DEPTH);
  localparam logic [OW-1:0] C_AF   = OW'(AF_TH);
  localparam logic [OW-1:0] C_AE   = OW'(AE_TH);
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);

  logic [PW-1:0]         wptr, rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wa, ra;
  logic                  exp_valid, exp_ack, exp_ovf, exp_udf, exp_dvld;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [7:0]            mism;
  logic [2:0]            mism_code;

  always_comb begin
    wa = wr_en && (occupancy != C_FULL);
    ra = rd_en && (occupancy != '0);
  end

  always_comb begin
    mism    = '0;
    mism[0] = full        != (occupancy == C_FULL);
    mism[1] = empty       != (occupancy == '0);
    mism[2] = almostfull  != (occupancy >= C_AF);
    mism[3] = almostempty != (occupancy <= C_AE);
    // Registered checks stay masked until one expectation has been captured after reset.
    mism[4] = exp_valid && (wr_ack    != exp_ack);
    mism[5] = exp_valid && (overflow  != exp_ovf);
    mism[6] = exp_valid && (underflow != exp_udf);
    mism[7] = exp_valid && exp_dvld && (data_out != exp_data);
  end

  always_comb begin
    mism_code = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (mism[i-1]) mism_code = 3'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (wa) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      wptr      <= '0;
      rptr      <= '0;
      exp_valid <= 1'b0;
      exp_ack   <= 1'b0;
      exp_ovf   <= 1'b0;
      exp_udf   <= 1'b0;
      exp_dvld  <= 1'b0;
      exp_data  <= '0;
    end else begin
      if (wa && !ra)      occupancy <= occupancy + OW'(1);
      else if (!wa && ra) occupancy <= occupancy - OW'(1);
      if (wa) wptr <= (wptr == P_LAST) ? '0 : wptr + PW'(1);
      if (ra) begin
        rptr     <= (rptr == P_LAST) ? '0 : rptr + PW'(1);
        exp_data <= mem[rptr];
      end
      exp_valid <= 1'b1;
      exp_ack   <= wa;
      exp_ovf   <= wr_en && (occupancy == C_FULL);
      exp_udf   <= rd_en && (occupancy == '0);
      exp_dvld  <= ra;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vec         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_code  <= '0;
    end else if (clr) begin
      err_vec         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_code  <= '0;
    end else if (mism != '0) begin
      err_vec <= err_vec | mism;
      if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_code  <= mism_code;
      end
    end
  end

  assign err_any = |err_vec;

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Bench for fifo_protocol_checker: plays a well-behaved FIFO from a queue model, plants faults
// on chosen signals and predicts the checker's error state from the FIFO rules.
module tb_fifo_protocol_checker;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF_TH = DEPTH - 1;
  localparam int AE_TH = 1;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n, clr, wr_en, rd_en;
  logic [DW-1:0] data_in, data_out;
  logic          full, empty, almostfull, almostempty;
  logic          wr_ack, overflow, underflow;
  logic [7:0]    err_vec;
  logic          err_any;
  logic [CW-1:0] err_count;
  logic          first_err_valid;
  logic [2:0]    first_err_code;
  logic [3:0]    occupancy;

  always #5 clk = ~clk;

  fifo_protocol_checker #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty), .wr_ack(wr_ack),
    .overflow(overflow), .underflow(underflow), .err_vec(err_vec), .err_any(err_any),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_code(first_err_code), .occupancy(occupancy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: FIFO contents as a queue plus the checker's predicted error state.
  logic [DW-1:0] q[$];
  logic          p_valid, p_ack, p_ovf, p_udf, p_dvld;
  logic [DW-1:0] p_data;
  logic [7:0]    m_vec;
  int            m_cnt;
  logic          m_fv;
  int            m_code;

  typedef struct {
    logic          wr, rd, clr;
    logic [3:0]    ff;
    logic [2:0]    rf;
    logic          df;
    logic [DW-1:0] din;
    int            occ;
    int            cnt;
    logic [7:0]    vec;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    p_valid = 0; p_ack = 0; p_ovf = 0; p_udf = 0; p_dvld = 0; p_data = '0;
    m_vec = '0; m_cnt = 0; m_fv = 0; m_code = 0;
  endtask

  task automatic drive_idle();
    clr = 0; wr_en = 0; rd_en = 0; data_in = '0; data_out = '0;
    full = 0; empty = 1; almostfull = 0; almostempty = 1;
    wr_ack = 0; overflow = 0; underflow = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".err_vec"}, 32'(err_vec), 32'(m_vec));
    chk({tag, ".err_any"}, 32'(err_any), 32'(m_vec != 0));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
    chk({tag, ".first_valid"}, 32'(first_err_valid), 32'(m_fv));
    chk({tag, ".first_code"}, 32'(first_err_code), 32'(m_code));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input logic wr, input logic rd, input logic clr_i, input logic [3:0] ff,
                      input logic [2:0] rf, input logic df, input logic [DW-1:0] din,
                      input string tag);
    int         n;
    logic       e_full, e_empty, e_af, e_ae, wa, ra;
    logic [7:0] mm;
    n = q.size();
    e_full = (n == DEPTH); e_empty = (n == 0); e_af = (n >= AF_TH); e_ae = (n <= AE_TH);
    wr_en = wr; rd_en = rd; clr = clr_i; data_in = din;
    full = e_full ^ ff[0]; empty = e_empty ^ ff[1];
    almostfull = e_af ^ ff[2]; almostempty = e_ae ^ ff[3];
    wr_ack = p_ack ^ rf[0]; overflow = p_ovf ^ rf[1]; underflow = p_udf ^ rf[2];
    data_out = df ? 16'h00FF : p_data;
    mm = '0;
    mm[0] = full != e_full; mm[1] = empty != e_empty;
    mm[2] = almostfull != e_af; mm[3] = almostempty != e_ae;
    if (p_valid) begin
      mm[4] = wr_ack != p_ack; mm[5] = overflow != p_ovf; mm[6] = underflow != p_udf;
      mm[7] = p_dvld && (data_out != p_data);
    end
    @(posedge clk);
    if (clr_i) begin
      m_vec = '0; m_cnt = 0; m_fv = 0; m_code = 0;
    end else if (mm != 0) begin
      m_vec |= mm;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (!m_fv) begin
        m_fv = 1;
        for (int i = 0; i < 8; i++) if (mm[i]) begin m_code = i; break; end
      end
    end
    wa = wr && n < DEPTH;
    ra = rd && n > 0;
    if (ra) p_data = q.pop_front();
    if (wa) q.push_back(din);
    p_ack = wa; p_ovf = wr && n == DEPTH; p_udf = rd && n == 0; p_dvld = ra; p_valid = 1;
    #1;
    check_outputs(tag);
  endtask

  task automatic add(input logic wr, input logic rd, input logic c, input logic [3:0] ff,
                     input logic [2:0] rf, input logic df, input logic [DW-1:0] din,
                     input int occ, input int cnt, input logic [7:0] vec);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = c; v.ff = ff; v.rf = rf; v.df = df; v.din = din;
    v.occ = occ; v.cnt = cnt; v.vec = vec;
    tbl.push_back(v);
  endtask

  initial begin
    // Fill to 8 and attempt a 9th write (overflow expected next cycle).
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 0, 0, 16'(k), k, 0, 8'h00);
    add(1, 0, 0, 0, 0, 0, 16'h0009, 8, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 8, 0, 8'h00);
    // Drain; the 3rd read's data is checked during the 4th read and is corrupted to 0x00FF.
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, 0, 0, k == 4, 16'h0, 8 - k, (k >= 4) ? 1 : 0, (k >= 4) ? 8'h80 : 8'h00);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'h80);
    add(0, 0, 1, 0, 0, 0, 16'h0, 0, 0, 8'h00);
    // Handshake fault: write at c=3, wr_ack withheld on the following cycle.
    for (int k = 1; k <= 3; k++) add(1, 0, 0, 0, 0, 0, 16'(16'h10 + k), k, 0, 8'h00);
    add(1, 0, 0, 0, 0, 0, 16'h0014, 4, 0, 8'h00);
    add(0, 0, 0, 0, 3'b001, 0, 16'h0, 4, 1, 8'h10);
    add(0, 0, 1, 0, 0, 0, 16'h0, 4, 0, 8'h00);
    // Simultaneous requests at c=0 and c=DEPTH.
    for (int k = 1; k <= 4; k++) add(0, 1, 0, 0, 0, 0, 16'h0, 4 - k, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 8'h00);
    add(1, 1, 0, 0, 0, 0, 16'h0055, 1, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 8'h00);
    for (int k = 2; k <= 8; k++) add(1, 0, 0, 0, 0, 0, 16'(16'h60 + k), k, 0, 8'h00);
    add(1, 1, 0, 0, 0, 0, 16'h0099, 7, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 16'h0, 7, 0, 8'h00);
    // Five flag errors at occupancy 4, then clr in a cycle that also mismatches.
    for (int k = 1; k <= 3; k++) add(0, 1, 0, 0, 0, 0, 16'h0, 7 - k, 0, 8'h00);
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 4'b0100, 0, 0, 16'h0, 4, k, 8'h04);
    add(0, 0, 1, 4'b0100, 0, 0, 16'h0, 4, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 16'h0, 4, 0, 8'h00);

    model_reset();
    drive_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1;
    step(0, 0, 0, 0, 0, 0, 16'h0, "idle");
    step(0, 0, 0, 0, 0, 0, 16'h0, "idle");

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].ff, tbl[i].rf, tbl[i].df, tbl[i].din, "tbl");
      chk($sformatf("tbl[%0d].occ", i), 32'(occupancy), 32'(tbl[i].occ));
      chk($sformatf("tbl[%0d].cnt", i), 32'(err_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl[%0d].vec", i), 32'(err_vec), 32'(tbl[i].vec));
    end
    chk("tbl.code", 32'(first_err_code), 32'd0);

    // Random traffic with occasional planted faults and clears, biased in phases to reach both ends.
    for (int i = 0; i < 800; i++) begin
      logic       wr, rd, c, df;
      logic [3:0] ff;
      logic [2:0] rf;
      int         pw;
      pw = ((i / 80) % 2 == 0) ? 75 : 25;
      wr = $urandom_range(0, 99) < pw;
      rd = $urandom_range(0, 99) < (100 - pw);
      c  = $urandom_range(0, 39) == 0;
      ff = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      rf = ($urandom_range(0, 14) == 0) ? 3'($urandom_range(1, 7)) : 3'h0;
      df = $urandom_range(0, 14) == 0;
      step(wr, rd, c, ff, rf, df, 16'($urandom), "rand");
    end

    // Make sure error state is nonzero, then reset asynchronously between edges.
    step(1, 0, 0, 4'b0001, 0, 0, 16'h1234, "prerst");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst_n = 1;
    step(0, 0, 0, 4'b0010, 3'b111, 0, 16'h0, "post_rst");
    step(1, 0, 0, 0, 0, 0, 16'hBEEF, "post_rst");
    step(0, 1, 0, 0, 0, 0, 16'h0, "post_rst");
    step(0, 0, 0, 0, 0, 0, 16'h0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
